gray_conv_pipe: RTL and testbench

// - Pipelined, bidirectional Gray/binary code converter with valid/ready handshake.
// - Per-transaction mode: Gray->binary (prefix XOR from MSB) or binary->Gray (b ^ b>>1).
// - XOR chain is split over NUM_STAGES register stages so wide counters close timing.
// - Sits on CDC pointer paths: after async FIFO synchronisers and in counter/encoder fabric.

---
 rtl/gray_pkg.sv | 22 ++
 rtl/gray_conv_pipe_if.sv | 25 ++
 rtl/gray_conv_stage.sv | 65 ++++++
 rtl/gray_conv_pipe.sv | 91 +++++++++
 tb/tb_gray_conv_pipe.sv | 216 +++++++++++++++++++++
 5 files changed

// File: rtl/gray_pkg.sv
// Shared types and helpers for the pipelined Gray/binary converter.
// Stateless: zero latency, no backpressure involvement.
package gray_pkg;

  typedef enum logic {GRAY2BIN = 1'b0, BIN2GRAY = 1'b1} gray_mode_e;

  localparam int POP_W = 256;

  function automatic int seg_width(input int data_width, input int num_stages);
    return (data_width + num_stages - 1) / num_stages;
  endfunction

  function automatic int unsigned popcount(input logic [POP_W-1:0] v);
    int unsigned n;
    n = 0;
    for (int i = 0; i < POP_W; i++) begin
      if (v[i]) n++;
    end
    return n;
  endfunction

endpackage

// File: rtl/gray_conv_pipe_if.sv
// Upstream/downstream valid-ready bundle of the Gray converter; slave = converter side.
// Pure wiring: no latency, ready/valid semantics defined by the converter.
interface gray_conv_pipe_if #(parameter int DATA_WIDTH = 16);

  gray_pkg::gray_mode_e    mode_i;
  logic [DATA_WIDTH-1:0]   data_in_i;
  logic                    in_valid_i;
  logic                    in_ready_o;
  logic [DATA_WIDTH-1:0]   data_out_o;
  gray_pkg::gray_mode_e    mode_o;
  logic                    out_valid_o;
  logic                    out_ready_i;
  logic                    step_err_o;

  modport master (
    output mode_i, data_in_i, in_valid_i, out_ready_i,
    input  in_ready_o, data_out_o, mode_o, out_valid_o, step_err_o
  );

  modport slave (
    input  mode_i, data_in_i, in_valid_i, out_ready_i,
    output in_ready_o, data_out_o, mode_o, out_valid_o, step_err_o
  );

endinterface

// File: rtl/gray_conv_stage.sv
// One pipeline slice: resolves GRAY2BIN bits SEG_MSB..SEG_LSB (stage 0 also does all of BIN2GRAY).
// Latency 1; loads when empty or when downstream accepts (in_rdy = !out_vld | out_rdy).
module gray_conv_stage
  import gray_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int SEG_MSB    = 15,
  parameter int SEG_LSB    = 8,
  parameter bit FIRST      = 1'b0
) (
  input  logic                  clk_i,
  input  logic                  arst_ni,
  input  logic                  in_vld,
  output logic                  in_rdy,
  input  gray_mode_e            in_mode,
  input  logic [DATA_WIDTH-1:0] in_word,
  output logic                  out_vld,
  input  logic                  out_rdy,
  output gray_mode_e            out_mode,
  output logic [DATA_WIDTH-1:0] out_word
);

  logic                  carry_in;
  logic [DATA_WIDTH-1:0] nxt_word;

  // The carry is the already-resolved binary bit just above this segment.
  if (SEG_MSB >= DATA_WIDTH - 1 || SEG_MSB < SEG_LSB) begin : g_nocarry
    assign carry_in = 1'b0;
  end else begin : g_carry
    assign carry_in = in_word[SEG_MSB+1];
  end

  always_comb begin
    logic c;
    c        = carry_in;
    nxt_word = in_word;
    if (in_mode == BIN2GRAY) begin
      if (FIRST) nxt_word = in_word ^ (in_word >> 1);
    end else begin
      for (int i = DATA_WIDTH - 1; i >= 0; i--) begin
        if (i <= SEG_MSB && i >= SEG_LSB) begin
          c           = c ^ in_word[i];
          nxt_word[i] = c;
        end
      end
    end
  end

  assign in_rdy = !out_vld | out_rdy;

  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      out_vld  <= 1'b0;
      out_mode <= GRAY2BIN;
      out_word <= '0;
    end else if (in_rdy) begin
      out_vld <= in_vld;
      if (in_vld) begin
        out_mode <= in_mode;
        out_word <= nxt_word;
      end
    end
  end

endmodule

// File: rtl/gray_conv_pipe.sv
// Pipelined Gray<->binary converter, latency NUM_STAGES, one word/cycle; combinational ready chain, no skid.
// Optional GRAY2BIN step-violation pulse under GRAY_CONV_PIPE_STEP_CHECK_EN.
module gray_conv_pipe
  import gray_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int NUM_STAGES = 2
) (
  input  logic             clk_i,
  input  logic             arst_ni,
  gray_conv_pipe_if.slave  bus
);

  localparam int SW = seg_width(DATA_WIDTH, NUM_STAGES);

  logic                  rst_done;
  logic                  vld  [NUM_STAGES+1];
  logic                  rdy  [NUM_STAGES+1];
  gray_mode_e            mode [NUM_STAGES+1];
  logic [DATA_WIDTH-1:0] word [NUM_STAGES+1];

  // Holds in_ready_o low through reset and releases it on the first clock afterwards.
  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) rst_done <= 1'b0;
    else          rst_done <= 1'b1;
  end

  assign vld[0]          = bus.in_valid_i & rst_done;
  assign mode[0]         = bus.mode_i;
  assign word[0]         = bus.data_in_i;
  assign rdy[NUM_STAGES] = bus.out_ready_i;

  for (genvar k = 0; k < NUM_STAGES; k++) begin : g_stage
    localparam int MSB     = DATA_WIDTH - 1 - k * SW;
    localparam int LSB_RAW = DATA_WIDTH - (k + 1) * SW;
    localparam int LSB     = (k == NUM_STAGES - 1 || LSB_RAW < 0) ? 0 : LSB_RAW;

    gray_conv_stage #(
      .DATA_WIDTH (DATA_WIDTH),
      .SEG_MSB    (MSB),
      .SEG_LSB    (LSB),
      .FIRST      (k == 0)
    ) u_stage (
      .clk_i    (clk_i),
      .arst_ni  (arst_ni),
      .in_vld   (vld[k]),
      .in_rdy   (rdy[k]),
      .in_mode  (mode[k]),
      .in_word  (word[k]),
      .out_vld  (vld[k+1]),
      .out_rdy  (rdy[k+1]),
      .out_mode (mode[k+1]),
      .out_word (word[k+1])
    );
  end

  assign bus.in_ready_o  = rdy[0] & rst_done;
  assign bus.out_valid_o = vld[NUM_STAGES];
  assign bus.mode_o      = mode[NUM_STAGES];
  assign bus.data_out_o  = word[NUM_STAGES];

`ifdef GRAY_CONV_PIPE_STEP_CHECK_EN
  logic [DATA_WIDTH-1:0] last_gray;
  logic                  have_last;
  logic                  step_err_q;
  logic                  g2b_acc;

  assign g2b_acc = bus.in_valid_i & bus.in_ready_o & (bus.mode_i == GRAY2BIN);

  // BIN2GRAY words neither update nor are compared against the tracked Gray value.
  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      last_gray  <= '0;
      have_last  <= 1'b0;
      step_err_q <= 1'b0;
    end else begin
      step_err_q <= 1'b0;
      if (g2b_acc) begin
        last_gray  <= bus.data_in_i;
        have_last  <= 1'b1;
        step_err_q <= have_last && (popcount(POP_W'(last_gray ^ bus.data_in_i)) > 1);
      end
    end
  end

  assign bus.step_err_o = step_err_q;
`else
  assign bus.step_err_o = 1'b0;
`endif

endmodule

// File: tb/tb_gray_conv_pipe.sv
// Directed checks on a 4-bit/2-stage converter plus a random scoreboard run on a 32-bit/3-stage one.
module tb_gray_conv_pipe;
  import gray_pkg::*;

  logic clk = 1'b0;
  logic arst_n = 1'b0;
  always #5 clk = ~clk;

`ifdef GRAY_CONV_PIPE_STEP_CHECK_EN
  localparam logic [31:0] STEP_ON = 32'd1;
`else
  localparam logic [31:0] STEP_ON = 32'd0;
`endif

  localparam int NRND = 10000;

  gray_conv_pipe_if #(.DATA_WIDTH(4))  a ();
  gray_conv_pipe_if #(.DATA_WIDTH(32)) b ();

  gray_conv_pipe #(.DATA_WIDTH(4), .NUM_STAGES(2)) dut (
    .clk_i(clk), .arst_ni(arst_n), .bus(a.slave)
  );
  gray_conv_pipe #(.DATA_WIDTH(32), .NUM_STAGES(3)) dut32 (
    .clk_i(clk), .arst_ni(arst_n), .bus(b.slave)
  );

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  function automatic logic [31:0] ref_g2b(input logic [31:0] g);
    logic [31:0] r;
    r[31] = g[31];
    for (int i = 30; i >= 0; i--) r[i] = r[i+1] ^ g[i];
    return r;
  endfunction

  function automatic logic [31:0] ref_b2g(input logic [31:0] v);
    return v ^ (v >> 1);
  endfunction

  // Present one word; returns 1 ns after the accepting edge with valid dropped.
  task automatic push_a(input gray_mode_e m, input logic [3:0] d);
    a.mode_i     = m;
    a.data_in_i  = d;
    a.in_valid_i = 1'b1;
    @(posedge clk); #1;
    a.in_valid_i = 1'b0;
  endtask

  initial begin
    logic [32:0] q[$];
    logic [32:0] e;
    logic        acc;
    int          sent, rcvd, cyc;

    a.in_valid_i = 1'b0; a.mode_i = GRAY2BIN; a.data_in_i = '0; a.out_ready_i = 1'b1;
    b.in_valid_i = 1'b0; b.mode_i = GRAY2BIN; b.data_in_i = '0; b.out_ready_i = 1'b1;

    // Reset state
    #12;
    check("rst_in_ready",  32'(a.in_ready_o),  32'd0);
    check("rst_out_valid", 32'(a.out_valid_o), 32'd0);
    check("rst_data_out",  32'(a.data_out_o),  32'd0);
    check("rst_mode_out",  32'(a.mode_o),      32'd0);
    check("rst_step_err",  32'(a.step_err_o),  32'd0);
    @(negedge clk) arst_n = 1'b1;
    @(posedge clk); #1;
    check("ready_after_rst", 32'(a.in_ready_o), 32'd1);

    // Single GRAY2BIN word, latency 2
    push_a(GRAY2BIN, 4'b0110);
    @(negedge clk);
    check("lat_early_valid", 32'(a.out_valid_o), 32'd0);
    @(negedge clk);
    check("lat_valid", 32'(a.out_valid_o), 32'd1);
    check("g2b_0110",  32'(a.data_out_o),  32'h4);
    check("g2b_mode",  32'(a.mode_o),      32'd0);

    // Back-to-back mode change, no bubble
    push_a(BIN2GRAY, 4'b1011);
    push_a(GRAY2BIN, 4'b1000);
    @(negedge clk);
    check("b2b_w0_valid", 32'(a.out_valid_o), 32'd1);
    check("b2g_1011",     32'(a.data_out_o),  32'hE);
    check("b2b_w0_mode",  32'(a.mode_o),      32'd1);
    @(negedge clk);
    check("b2b_w1_valid", 32'(a.out_valid_o), 32'd1);
    check("g2b_1000",     32'(a.data_out_o),  32'hF);
    check("b2b_w1_mode",  32'(a.mode_o),      32'd0);
    @(negedge clk);
    check("b2b_drain", 32'(a.out_valid_o), 32'd0);

    // Backpressure: three words offered, two fit
    a.out_ready_i = 1'b0;
    a.mode_i = GRAY2BIN; a.data_in_i = 4'b0001; a.in_valid_i = 1'b1;
    #1;
    check("bp_rdy_w0", 32'(a.in_ready_o), 32'd1);
    @(posedge clk); #1;
    a.mode_i = BIN2GRAY; a.data_in_i = 4'b0110;
    @(negedge clk);
    check("bp_rdy_w1", 32'(a.in_ready_o), 32'd1);
    @(posedge clk); #1;
    a.mode_i = GRAY2BIN; a.data_in_i = 4'b0011;
    @(negedge clk);
    check("bp_full_rdy",  32'(a.in_ready_o),  32'd0);
    check("bp_out_valid", 32'(a.out_valid_o), 32'd1);
    check("bp_out_w0",    32'(a.data_out_o),  32'h1);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("bp_hold_rdy",  32'(a.in_ready_o), 32'd0);
    check("bp_hold_data", 32'(a.data_out_o), 32'h1);
    @(posedge clk); #1;
    a.out_ready_i = 1'b1;
    @(negedge clk);
    check("bp_accept_emit_rdy", 32'(a.in_ready_o), 32'd1);
    @(posedge clk); #1;
    a.in_valid_i = 1'b0;
    @(negedge clk);
    check("bp_out_w1",  32'(a.data_out_o), 32'h5);
    check("bp_mode_w1", 32'(a.mode_o),     32'd1);
    @(negedge clk);
    check("bp_out_w2",   32'(a.data_out_o),  32'h2);
    check("bp_w2_valid", 32'(a.out_valid_o), 32'd1);
    @(negedge clk);
    check("bp_empty", 32'(a.out_valid_o), 32'd0);

    // Step check (previous GRAY2BIN accepted word is 0011)
    push_a(GRAY2BIN, 4'b0001);
    @(negedge clk);
    check("step_d1", 32'(a.step_err_o), 32'd0);
    push_a(GRAY2BIN, 4'b0010);
    @(negedge clk);
    check("step_d2", 32'(a.step_err_o), STEP_ON);
    @(negedge clk);
    check("step_pulse_end", 32'(a.step_err_o), 32'd0);
    push_a(BIN2GRAY, 4'b1111);
    @(negedge clk);
    check("step_b2g_unchecked", 32'(a.step_err_o), 32'd0);
    push_a(GRAY2BIN, 4'b0011);
    @(negedge clk);
    check("step_b2g_untracked", 32'(a.step_err_o), 32'd0);
    push_a(GRAY2BIN, 4'b0010);
    @(negedge clk);
    check("step_0011_0010", 32'(a.step_err_o), 32'd0);

    // Reset with two words in flight
    a.out_ready_i = 1'b0;
    push_a(GRAY2BIN, 4'b0110);
    push_a(BIN2GRAY, 4'b1011);
    @(negedge clk);
    check("inflight_valid", 32'(a.out_valid_o), 32'd1);
    #2 arst_n = 1'b0;
    #1;
    check("midrst_valid", 32'(a.out_valid_o), 32'd0);
    check("midrst_ready", 32'(a.in_ready_o),  32'd0);
    @(negedge clk);
    arst_n = 1'b1;
    a.out_ready_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("postrst_idle", 32'(a.out_valid_o), 32'd0);
    end
    push_a(GRAY2BIN, 4'b1000);
    @(negedge clk);
    @(negedge clk);
    check("postrst_valid", 32'(a.out_valid_o), 32'd1);
    check("postrst_data",  32'(a.data_out_o),  32'hF);

    // Random traffic on the 32-bit / 3-stage instance
    sent = 0; rcvd = 0; cyc = 0;
    @(posedge clk); #1;
    while (rcvd < NRND && cyc < 60000) begin
      @(negedge clk);
      cyc++;
      if (b.out_valid_o && b.out_ready_i) begin
        if (q.size() == 0) begin
          check("rnd_unexpected_out", 32'(q.size()), 32'd1);
        end else begin
          e = q.pop_front();
          check("rnd_data", b.data_out_o,     e[31:0]);
          check("rnd_mode", 32'(b.mode_o),    32'(e[32]));
          rcvd++;
        end
      end
      acc = b.in_valid_i && b.in_ready_o;
      if (acc) begin
        q.push_back({b.mode_i == BIN2GRAY,
                     (b.mode_i == BIN2GRAY) ? ref_b2g(b.data_in_i) : ref_g2b(b.data_in_i)});
        sent++;
      end
      @(posedge clk); #1;
      if (acc || !b.in_valid_i) begin
        if (sent < NRND && $urandom_range(3) != 0) begin
          b.in_valid_i = 1'b1;
          b.data_in_i  = $urandom;
          b.mode_i     = ($urandom_range(1) == 1) ? BIN2GRAY : GRAY2BIN;
        end else begin
          b.in_valid_i = 1'b0;
        end
      end
      b.out_ready_i = ($urandom_range(3) != 0);
    end
    check("rnd_received", 32'(rcvd),     32'(NRND));
    check("rnd_q_empty",  32'(q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
